// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with EX/MEM and MEM/WB operand forwarding and load-use detection.
// Latency: one cycle from ID capture to alu_*/ex_*; forwarding muxes add no latency.
// Backpressure: stall freezes EX (forwarded operand data keeps refreshing); flush or load-use turns EX into a bubble.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  // decode slot
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic            id_uses_rs2,
  input  logic [3:0]      id_alu_control,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_branch,
  // pipeline control
  input  logic            stall,
  input  logic            flush,
  // forwarding sources
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  // ALU side
  output logic [XLEN-1:0] alu_inp1,
  output logic [XLEN-1:0] alu_inp2,
  output logic [3:0]      alu_control,
  // EX stage contents
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic [XLEN-1:0] ex_store_data,
  // hazard back to fetch/decode
  output logic            load_use_stall
);

  // Everything held in EX, kept together so bubble/hold/load are whole-record operations.
  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic            use_imm;
    logic [3:0]      alu_ctl;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
  } ex_reg_t;

  ex_reg_t ex_q;
  ex_reg_t ex_d;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            mem_hit_rs1;
  logic            mem_hit_rs2;
  logic            wb_hit_rs1;
  logic            wb_hit_rs2;
  logic            hazard_raw;

  // Source match per operand; x0 never matches because a writer of x0 is rejected.
  always_comb begin
    mem_hit_rs1 = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_q.rs1);
    mem_hit_rs2 = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_q.rs2);
    wb_hit_rs1  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_q.rs1);
    wb_hit_rs2  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_q.rs2);
  end

  // Forwarding muxes: the younger EX/MEM result wins over MEM/WB, else the captured register data.
  always_comb begin
    if (mem_hit_rs1)
      fwd_rs1 = mem_result;
    else if (wb_hit_rs1)
      fwd_rs1 = wb_result;
    else
      fwd_rs1 = ex_q.rs1_data;

    if (mem_hit_rs2)
      fwd_rs2 = mem_result;
    else if (wb_hit_rs2)
      fwd_rs2 = wb_result;
    else
      fwd_rs2 = ex_q.rs2_data;
  end

  // Load in EX whose destination the decode instruction reads; rs2 only counts if actually read.
  always_comb begin
    hazard_raw = ex_q.vld && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                 ((id_rs1 == ex_q.rd) || (id_uses_rs2 && (id_rs2 == ex_q.rd)));
    // A held or killed pipe already stops decode, so the hazard request is suppressed then.
    load_use_stall = hazard_raw && !stall && !flush;
  end

  // Next EX contents: flush beats stall beats load-use bubble beats normal capture.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      // Operands keep absorbing forwards so a value retiring from WB during the hold survives.
      ex_d.rs1_data = fwd_rs1;
      ex_d.rs2_data = fwd_rs2;
    end else if (load_use_stall) begin
      ex_d = '0;
    end else begin
      ex_d.vld       = id_valid;
      ex_d.pc        = id_pc;
      ex_d.imm       = id_imm;
      ex_d.rs1_data  = id_rs1_data;
      ex_d.rs2_data  = id_rs2_data;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.rd        = id_rd;
      ex_d.use_imm   = id_use_imm;
      ex_d.alu_ctl   = id_alu_control;
      ex_d.reg_write = id_reg_write && id_valid;
      ex_d.mem_read  = id_mem_read  && id_valid;
      ex_d.mem_write = id_mem_write && id_valid;
      ex_d.branch    = id_branch    && id_valid;
    end
  end

  // EX register; reset leaves a bubble with all fields cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ex_q <= '0;
    else
      ex_q <= ex_d;
  end

  // Output drive; control bits are re-gated by valid so a bubble can never write state.
  always_comb begin
    alu_inp1      = fwd_rs1;
    alu_inp2      = ex_q.use_imm ? ex_q.imm : fwd_rs2;
    ex_store_data = fwd_rs2;
    alu_control   = ex_q.alu_ctl;
    ex_valid      = ex_q.vld;
    ex_pc         = ex_q.pc;
    ex_imm        = ex_q.imm;
    ex_rd         = ex_q.rd;
    ex_reg_write  = ex_q.vld && ex_q.reg_write;
    ex_mem_read   = ex_q.vld && ex_q.mem_read;
    ex_mem_write  = ex_q.vld && ex_q.mem_write;
    ex_branch     = ex_q.vld && ex_q.branch;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, load-use, stall refresh, flush/stall, bubbles.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 time unit after that or later.
// Each scenario task compares inline and bumps the shared counters.
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk;
  logic            rst_n;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic            id_use_imm;
  logic            id_uses_rs2;
  logic [3:0]      id_alu_control;
  logic [RA_W-1:0] id_rd;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_branch;
  logic            stall;
  logic            flush;
  logic            mem_reg_write;
  logic [RA_W-1:0] mem_rd;
  logic [XLEN-1:0] mem_result;
  logic            wb_reg_write;
  logic [RA_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_result;
  logic [XLEN-1:0] alu_inp1;
  logic [XLEN-1:0] alu_inp2;
  logic [3:0]      alu_control;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [RA_W-1:0] ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_branch;
  logic [XLEN-1:0] ex_store_data;
  logic            load_use_stall;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_uses_rs2(id_uses_rs2), .id_alu_control(id_alu_control),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch),
    .stall(stall), .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_control(alu_control),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_use_imm = 0; id_uses_rs2 = 0; id_alu_control = '0; id_rd = '0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_branch = 0;
    stall = 0; flush = 0;
    mem_reg_write = 0; mem_rd = '0; mem_result = '0;
    wb_reg_write = 0; wb_rd = '0; wb_result = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      id_valid = 1; id_pc = $urandom; id_rs1 = RA_W'($urandom); id_rs2 = RA_W'($urandom);
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_use_imm = 1'($urandom); id_alu_control = 4'($urandom); id_rd = RA_W'($urandom);
      id_reg_write = 1; id_mem_read = 1; id_mem_write = 1; id_branch = 1;
      tick();
    end
    mem_reg_write = 0; wb_reg_write = 0;
    #1;
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", ex_valid); end
    n_cmp++; if (alu_control !== 4'h0) begin n_bad++; $display("FAIL rst_aluctl: got %h want 0", alu_control); end
    n_cmp++; if (ex_pc !== 32'h0 || ex_imm !== 32'h0 || ex_rd !== 5'h0) begin n_bad++; $display("FAIL rst_fields: pc=%h imm=%h rd=%h want 0", ex_pc, ex_imm, ex_rd); end
    n_cmp++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch} !== 4'b0) begin n_bad++; $display("FAIL rst_ctl: got %b want 0000", {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}); end
    n_cmp++; if (alu_inp1 !== 32'h0 || alu_inp2 !== 32'h0 || ex_store_data !== 32'h0) begin n_bad++; $display("FAIL rst_data: inp1=%h inp2=%h st=%h want 0", alu_inp1, alu_inp2, ex_store_data); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    tick();
    id_valid = 1; id_rs1 = 5'd1; id_rs1_data = 32'd5; id_imm = 32'd7; id_use_imm = 1;
    id_alu_control = 4'h6; id_pc = 32'h100;
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (alu_inp1 !== 32'd5) begin n_bad++; $display("FAIL rel_inp1: got %h want 5", alu_inp1); end
    n_cmp++; if (alu_inp2 !== 32'd7) begin n_bad++; $display("FAIL rel_inp2: got %h want 7", alu_inp2); end
    n_cmp++; if (ex_valid !== 1'b1 || alu_control !== 4'h6 || ex_pc !== 32'h100) begin n_bad++; $display("FAIL rel_fields: v=%b ctl=%h pc=%h want 1/6/100", ex_valid, alu_control, ex_pc); end
  endtask

  task automatic test_forward();
    idle_inputs();
    id_valid = 1; id_rs1 = 5'd3; id_rs1_data = 32'h11; id_rs2 = 5'd3; id_rs2_data = 32'h55;
    id_use_imm = 0; id_uses_rs2 = 1; id_imm = 32'h77;
    tick();
    idle_inputs();
    mem_reg_write = 1; mem_rd = 5'd3; mem_result = 32'h22;
    wb_reg_write = 1; wb_rd = 5'd3; wb_result = 32'h33;
    #1;
    n_cmp++; if (alu_inp1 !== 32'h22) begin n_bad++; $display("FAIL fwd_mem1: got %h want 22", alu_inp1); end
    n_cmp++; if (alu_inp2 !== 32'h22 || ex_store_data !== 32'h22) begin n_bad++; $display("FAIL fwd_mem2: inp2=%h st=%h want 22", alu_inp2, ex_store_data); end
    mem_reg_write = 0;
    #1;
    n_cmp++; if (alu_inp1 !== 32'h33) begin n_bad++; $display("FAIL fwd_wb1: got %h want 33", alu_inp1); end
    wb_rd = 5'd4; mem_reg_write = 1; mem_rd = 5'd2;
    #1;
    n_cmp++; if (alu_inp1 !== 32'h11 || ex_store_data !== 32'h55) begin n_bad++; $display("FAIL fwd_none: inp1=%h st=%h want 11/55", alu_inp1, ex_store_data); end
    @(posedge clk); #1;
    idle_inputs();
    id_valid = 1; id_rs1 = 5'd0; id_rs1_data = 32'h44; id_rs2 = 5'd0; id_rs2_data = 32'h0;
    tick();
    idle_inputs();
    mem_reg_write = 1; mem_rd = 5'd0; mem_result = 32'h22;
    wb_reg_write = 1; wb_rd = 5'd0; wb_result = 32'h33;
    #1;
    n_cmp++; if (alu_inp1 !== 32'h44) begin n_bad++; $display("FAIL fwd_x0: got %h want 44", alu_inp1); end
    n_cmp++; if (ex_store_data !== 32'h0) begin n_bad++; $display("FAIL fwd_x0_rs2: got %h want 0", ex_store_data); end
    idle_inputs();
  endtask

  task automatic load_into_ex(input logic [RA_W-1:0] rd);
    idle_inputs();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = rd; id_pc = 32'h200;
    tick();
  endtask

  task automatic test_load_use();
    load_into_ex(5'd5);
    id_valid = 1; id_mem_read = 0; id_reg_write = 1; id_rd = 5'd6; id_pc = 32'h204;
    id_rs1 = 5'd1; id_rs2 = 5'd5; id_uses_rs2 = 1; id_rs2_data = 32'h0;
    #1;
    n_cmp++; if (load_use_stall !== 1'b1) begin n_bad++; $display("FAIL lu_rs2: got %b want 1", load_use_stall); end
    stall = 1;
    #1;
    n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL lu_mask_stall: got %b want 0", load_use_stall); end
    stall = 0; flush = 1;
    #1;
    n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL lu_mask_flush: got %b want 0", load_use_stall); end
    flush = 0;
    tick();
    n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin n_bad++; $display("FAIL lu_bubble: v=%b rw=%b mr=%b want 0", ex_valid, ex_reg_write, ex_mem_read); end
    n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL lu_once: got %b want 0", load_use_stall); end
    tick();
    wb_reg_write = 1; wb_rd = 5'd5; wb_result = 32'hAB;
    #1;
    n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_pc !== 32'h204) begin n_bad++; $display("FAIL lu_enter: v=%b rd=%h pc=%h want 1/6/204", ex_valid, ex_rd, ex_pc); end
    n_cmp++; if (ex_store_data !== 32'hAB) begin n_bad++; $display("FAIL lu_wbfwd: got %h want ab", ex_store_data); end
    // rs2 matches but is not read: no hazard
    load_into_ex(5'd5);
    id_valid = 1; id_rd = 5'd6; id_rs1 = 5'd1; id_rs2 = 5'd5; id_uses_rs2 = 0; id_mem_read = 0; id_pc = 32'h208;
    #1;
    n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL lu_norrs2: got %b want 0", load_use_stall); end
    tick();
    n_cmp++; if (ex_valid !== 1'b1 || ex_pc !== 32'h208) begin n_bad++; $display("FAIL lu_noenter: v=%b pc=%h want 1/208", ex_valid, ex_pc); end
    // rs1 dependence
    load_into_ex(5'd9);
    id_valid = 1; id_rs1 = 5'd9;
    #1;
    n_cmp++; if (load_use_stall !== 1'b1) begin n_bad++; $display("FAIL lu_rs1: got %b want 1", load_use_stall); end
    // load to x0 never stalls
    load_into_ex(5'd0);
    id_valid = 1; id_rs1 = 5'd0;
    #1;
    n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL lu_x0: got %b want 0", load_use_stall); end
    // invalid decode slot never stalls
    load_into_ex(5'd9);
    id_valid = 0; id_rs1 = 5'd9;
    #1;
    n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL lu_idinv: got %b want 0", load_use_stall); end
    idle_inputs();
  endtask

  task automatic test_stall_refresh();
    idle_inputs();
    id_valid = 1; id_rs2 = 5'd4; id_rs2_data = 32'h10; id_uses_rs2 = 1; id_rd = 5'd7;
    id_reg_write = 1; id_mem_write = 1; id_pc = 32'h300;
    tick();
    idle_inputs();
    id_valid = 1; id_pc = 32'h999; id_rd = 5'd1;
    stall = 1; wb_reg_write = 1; wb_rd = 5'd4; wb_result = 32'h99;
    tick();
    wb_reg_write = 0; wb_result = 32'h0;
    tick();
    tick();
    stall = 0;
    #1;
    n_cmp++; if (ex_store_data !== 32'h99) begin n_bad++; $display("FAIL stall_refresh: got %h want 99", ex_store_data); end
    n_cmp++; if (ex_pc !== 32'h300 || ex_rd !== 5'd7 || ex_mem_write !== 1'b1) begin n_bad++; $display("FAIL stall_hold: pc=%h rd=%h mw=%b want 300/7/1", ex_pc, ex_rd, ex_mem_write); end
    idle_inputs();
  endtask

  task automatic test_flush_vs_stall();
    idle_inputs();
    id_valid = 1; id_reg_write = 1; id_mem_write = 1; id_branch = 1; id_pc = 32'h400; id_alu_control = 4'h3;
    tick();
    flush = 1; stall = 1;
    tick();
    idle_inputs();
    n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0) begin n_bad++; $display("FAIL flush_stall: v=%b rw=%b mw=%b want 0", ex_valid, ex_reg_write, ex_mem_write); end
    n_cmp++; if (ex_pc !== 32'h0 || alu_control !== 4'h0 || ex_branch !== 1'b0) begin n_bad++; $display("FAIL flush_data: pc=%h ctl=%h br=%b want 0", ex_pc, alu_control, ex_branch); end
  endtask

  task automatic test_bubble();
    idle_inputs();
    id_valid = 0; id_reg_write = 1; id_mem_write = 1; id_mem_read = 1; id_branch = 1;
    tick();
    idle_inputs();
    n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin n_bad++; $display("FAIL bubble: v=%b rw=%b want 0", ex_valid, ex_reg_write); end
    n_cmp++; if ({ex_mem_read, ex_mem_write, ex_branch} !== 3'b0) begin n_bad++; $display("FAIL bubble_ctl: got %b want 000", {ex_mem_read, ex_mem_write, ex_branch}); end
  endtask

  task automatic test_reset_mid_stall();
    idle_inputs();
    id_valid = 1; id_reg_write = 1; id_pc = 32'h500; id_rs1_data = 32'h12;
    tick();
    stall = 1;
    tick();
    rst_n = 0;
    #1;
    n_cmp++; if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || alu_inp1 !== 32'h0) begin n_bad++; $display("FAIL rst_stall: v=%b pc=%h inp1=%h want 0", ex_valid, ex_pc, alu_inp1); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    tick();
    n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin n_bad++; $display("FAIL rst_stall_after: v=%b rw=%b want 0", ex_valid, ex_reg_write); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_forward();
    test_load_use();
    test_stall_refresh();
    test_flush_vs_stall();
    test_bubble();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage directly upstream of the ALU. Registers decoded operands and control from decode, applies EX/MEM and MEM/WB forwarding, and drives the ALU's `inp1`, `inp2` and `alu_control` inputs. Also produces:

- the load-use hazard signal back to fetch/decode;
- the store data and control bits consumed by the memory stage.

## Interface

Parameters:
- `XLEN`, 32, datapath width.
- `RA_W`, 5, register address width.

Ports (clock and reset first):
- Reset is asynchronous and active-low; the block uses one clock.
- `clk` in 1: single clock, all state on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `id_valid` in 1: decode slot holds a real instruction.
- `id_pc` in XLEN: PC of the decode instruction.
- `id_rs1`, `id_rs2` in RA_W: source register addresses.
- `id_rs1_data`, `id_rs2_data` in XLEN: register-file read data.
- `id_imm` in XLEN: sign-extended immediate.
- `id_use_imm` in 1: ALU operand 2 is the immediate, not rs2.
- `id_uses_rs2` in 1: instruction reads rs2. Applies to R-type, store and branch.
- `id_alu_control` in 4: ALU opcode, passed through unchanged.
- `id_rd` in RA_W: destination register.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch` in 1 each: control bits.
- `stall` in 1: downstream hold; the EX contents are frozen.
- `flush` in 1: kill; EX becomes a bubble.
- `mem_reg_write` in 1, `mem_rd` in RA_W, `mem_result` in XLEN: EX/MEM forwarding source.
- `wb_reg_write` in 1, `wb_rd` in RA_W, `wb_result` in XLEN: MEM/WB forwarding source.
- `alu_inp1`, `alu_inp2` out XLEN: ALU operands (combinational from state plus forwarding).
- `alu_control` out 4: registered ALU opcode.
- `ex_valid` out 1: EX holds a real instruction.
- `ex_pc` out XLEN, `ex_imm` out XLEN, `ex_rd` out RA_W: registered fields.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch` out 1 each: registered control, gated by `ex_valid`.
- `ex_store_data` out XLEN: forwarded rs2 value.
- `load_use_stall` out 1: combinational; upstream must hold IF/ID this cycle.

## Operation

Forwarding is computed per operand on the registered `rs1_q`/`rs2_q`:

- **Priority:** MEM match first, then WB match, then registered data.
- **MEM match:** `mem_reg_write` set, `mem_rd`≠0, `mem_rd`==`rs_q`.
- **WB match:** the same test applied to the WB inputs.
- **Register x0:** `rs_q`==0 never forwards and reads the registered data.

Outputs:
- `alu_inp1` = forwarded rs1.
- `alu_inp2` = `imm_q` if `use_imm_q`, else forwarded rs2.
- `ex_store_data` = forwarded rs2, always.

Hazard detection:
- `load_use_stall` = `ex_valid` & `ex_mem_read_q` & `ex_rd`≠0 & `id_valid` & (`id_rs1`==`ex_rd` | (`id_uses_rs2` & `id_rs2`==`ex_rd`)).
- The output is masked to 0 while `stall` or `flush` is high.

Register update on each rising edge, first matching rule wins:
1. `flush`: bubble. `ex_valid` and all control bits go to 0; data fields go to 0.
2. `stall`: hold all fields. Exception: `rs1_data_q`/`rs2_data_q` load their current forwarded values, so a result leaving WB during the hold is not lost.
3. `load_use_stall`: bubble, same as rule 1. The decode instruction is not consumed.
4. Otherwise: load all `id_*` fields; `ex_valid` takes `id_valid`. Control bits are ANDed with `id_valid`.

`alu_control` resets and bubbles to 4'b0000. It is a don't-care while `ex_valid`=0.

## Timing

- **Reset:** asynchronous assert drives every registered output to 0. Covers `ex_valid`, `alu_control`, `ex_pc`, `ex_imm`, `ex_rd`, all control bits and the internal data regs. Combinational outputs then read 0 unless a forward matches. Release is synchronous to `clk`.
- **Latency:** exactly one cycle from an ID capture to the values appearing on `alu_*`/`ex_*`.
- **Forwarding:** zero added latency; follows `mem_*`/`wb_*` within the same cycle.
- **Load-use:** exactly one bubble per load-use pair.
  - Cycle N: the load is in EX and a dependent instruction is in ID; `load_use_stall`=1.
  - Cycle N+1: the load is in MEM and EX is a bubble.
  - Cycle N+2: the dependent instruction enters EX and forwards from WB.
- **Simultaneous events:** `flush`+`stall` → flush. `stall` with hazard conditions → hold, and `load_use_stall`=0.
- **Reset mid-stall:** clears to bubble; no held state survives.

## Test plan

- **Reset:** hold `rst_n`=0 with random inputs → all registered outputs 0, `ex_valid`=0; release, then load `id_rs1_data`=5, `id_imm`=7, `id_use_imm`=1 → next cycle `alu_inp1`=5, `alu_inp2`=7.
- **Forward priority:** `rs1_q`=3, registered data 0x11, `mem_rd`=3 with `mem_result`=0x22, `wb_rd`=3 with `wb_result`=0x33, both write enables set → `alu_inp1`=0x22. Drop `mem_reg_write` → 0x33. Set `rs1_q`=0 with the same forwards → 0x11 (or 0 per register data).
- **Load-use:** load to x5 in EX; `id_rs2`=5, `id_uses_rs2`=1 → `load_use_stall`=1, next cycle `ex_valid`=0. Repeat with `id_uses_rs2`=0 → no stall.
- **Stall refresh:** `stall`=1 for 3 cycles while WB forwards x4=0x99 only in the first cycle, with `rs2_q`=4 → after release, `ex_store_data`=0x99.
- **Flush vs stall:** `flush`=`stall`=1 → next cycle `ex_valid`=0 and `ex_reg_write`=`ex_mem_write`=0.
- **Bubble propagation:** `id_valid`=0 with `id_reg_write`=1 → `ex_reg_write`=0.
